// File: rtl/x86_insn_encoder.sv
// Serializes one decoded x86-64 instruction record into a little-endian byte stream.
// Fields go out in the fixed order 0x66, REX, 0x0F, opcode, ModRM, SIB, disp, imm.
module x86_insn_encoder #(
    parameter int MAX_LEN = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_opsize,
    input  logic             in_rex_en,
    input  logic [3:0]       in_rex,
    input  logic             in_esc,
    input  logic [7:0]       in_opcode,
    input  logic             in_has_modrm,
    input  logic [7:0]       in_modrm,
    input  logic             in_has_sib,
    input  logic [7:0]       in_sib,
    input  logic [2:0]       in_disp_len,
    input  logic [31:0]      in_disp,
    input  logic [3:0]       in_imm_len,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic [3:0]       insn_len,
    output logic             err,
    output logic [CNT_W-1:0] insn_count
);

    // state | meaning
    // IDLE  | waiting for a record, in_ready high
    // PFX   | emitting 0x66 operand-size prefix
    // REX   | emitting REX byte 0x40|rex
    // ESC   | emitting 0x0F escape
    // OPC   | emitting primary opcode
    // MODRM | emitting ModRM
    // SIB   | emitting SIB
    // DISP  | emitting displacement bytes, LSB first
    // IMM   | emitting immediate bytes, LSB first
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PFX   = 4'd1,
        REX   = 4'd2,
        ESC   = 4'd3,
        OPC   = 4'd4,
        MODRM = 4'd5,
        SIB   = 4'd6,
        DISP  = 4'd7,
        IMM   = 4'd8
    } state_t;

    typedef struct packed {
        logic        opsize;
        logic        rex_en;
        logic [3:0]  rex;
        logic        esc;
        logic [7:0]  opcode;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [2:0]  disp_len;
        logic [31:0] disp;
        logic [3:0]  imm_len;
        logic [63:0] imm;
    } rec_t;

    state_t     state;
    rec_t       rec_q;
    rec_t       rec_in;
    logic [3:0] idx;
    logic [3:0] idx_inc;
    state_t     first_state;
    state_t     adv_state;
    logic [5:0] rec_len;
    logic       disp_ok;
    logic       imm_ok;
    logic       sib_ok;
    logic       len_ok;
    logic       rec_legal;

    // Earliest enabled field strictly after s; the later checks win, so they are the earlier fields.
    function automatic state_t next_field(input state_t s, input rec_t r);
        state_t n;
        n = IDLE;
        if (s < IMM   && r.imm_len != 4'd0)  n = IMM;
        if (s < DISP  && r.disp_len != 3'd0) n = DISP;
        if (s < SIB   && r.has_sib)          n = SIB;
        if (s < MODRM && r.has_modrm)        n = MODRM;
        if (s < OPC)                         n = OPC;
        if (s < ESC   && r.esc)              n = ESC;
        if (s < REX   && r.rex_en)           n = REX;
        if (s < PFX   && r.opsize)           n = PFX;
        return n;
    endfunction

    function automatic logic [7:0] field_byte(input state_t s, input logic [2:0] i, input rec_t r);
        logic [7:0] b;
        case (s)
            PFX:     b = 8'h66;
            REX:     b = {4'h4, r.rex};
            ESC:     b = 8'h0F;
            OPC:     b = r.opcode;
            MODRM:   b = r.modrm;
            SIB:     b = r.sib;
            DISP:    b = r.disp[{i[1:0], 3'b000} +: 8];
            IMM:     b = r.imm[{i, 3'b000} +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Multi-byte fields finish when the index reaches len-1; single-byte fields always finish.
    function automatic logic field_end(input state_t s, input logic [3:0] i, input rec_t r);
        logic e;
        case (s)
            DISP:    e = (i == ({1'b0, r.disp_len} - 4'd1));
            IMM:     e = (i == (r.imm_len - 4'd1));
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic is_last(input state_t s, input logic [3:0] i, input rec_t r);
        return field_end(s, i, r) && (next_field(s, r) == IDLE);
    endfunction

    assign rec_in = '{
        opsize:    in_opsize,
        rex_en:    in_rex_en,
        rex:       in_rex,
        esc:       in_esc,
        opcode:    in_opcode,
        has_modrm: in_has_modrm,
        modrm:     in_modrm,
        has_sib:   in_has_sib,
        sib:       in_sib,
        disp_len:  in_disp_len,
        disp:      in_disp,
        imm_len:   in_imm_len,
        imm:       in_imm
    };

    assign rec_len = 6'(in_opsize) + 6'(in_rex_en) + 6'(in_esc) + 6'd1
                   + 6'(in_has_modrm) + 6'(in_has_sib)
                   + 6'(in_disp_len) + 6'(in_imm_len);

    assign disp_ok   = (in_disp_len == 3'd0) || (in_disp_len == 3'd1) || (in_disp_len == 3'd4);
    assign imm_ok    = (in_imm_len == 4'd0) || (in_imm_len == 4'd1) || (in_imm_len == 4'd2)
                    || (in_imm_len == 4'd4) || (in_imm_len == 4'd8);
    assign sib_ok    = !in_has_sib || in_has_modrm;
    assign len_ok    = (rec_len <= 6'(MAX_LEN));
    assign rec_legal = disp_ok && imm_ok && sib_ok && len_ok;

    assign first_state = next_field(IDLE, rec_in);
    assign adv_state   = next_field(state, rec_q);
    assign idx_inc     = idx + 4'd1;
    assign in_ready    = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rec_q      <= '0;
            idx        <= 4'd0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            out_last   <= 1'b0;
            insn_len   <= 4'd0;
            err        <= 1'b0;
            insn_count <= '0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    if (!rec_legal) begin
                        err <= 1'b1;
                    end else begin
                        rec_q     <= rec_in;
                        insn_len  <= rec_len[3:0];
                        state     <= first_state;
                        idx       <= 4'd0;
                        out_valid <= 1'b1;
                        out_byte  <= field_byte(first_state, 3'd0, rec_in);
                        out_last  <= is_last(first_state, 4'd0, rec_in);
                    end
                end
            end else if (out_valid && out_ready) begin
                if (out_last) begin
                    state      <= IDLE;
                    idx        <= 4'd0;
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    insn_count <= insn_count + CNT_W'(1);
                end else if (field_end(state, idx, rec_q)) begin
                    state    <= adv_state;
                    idx      <= 4'd0;
                    out_byte <= field_byte(adv_state, 3'd0, rec_q);
                    out_last <= is_last(adv_state, 4'd0, rec_q);
                end else begin
                    idx      <= idx_inc;
                    out_byte <= field_byte(state, idx_inc[2:0], rec_q);
                    out_last <= is_last(state, idx_inc, rec_q);
                end
            end
        end
    end

endmodule

// File: doc/x86_insn_encoder.md
Name: x86_insn_encoder

Overview:
- Serializes one decoded x86-64 instruction record into a little-endian byte stream, one byte per handshake.
- It is the encode-side counterpart of the front-end opcode/ModRM decode tables.
- Used by self-check benches and the trace/replay path to regenerate instruction bytes from decoded fields.
- Input is a valid/ready record interface; output is a valid/ready byte stream with an end-of-instruction marker.

Parameters:
MAX_LEN, 15, architectural instruction length limit in bytes; longer records are rejected.
CNT_W, 32, width of the emitted-instruction counter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction record valid
in_ready  output  1  encoder can accept a record (high only in IDLE)
in_opsize  input  1  emit 0x66 operand-size prefix
in_rex_en  input  1  emit REX byte
in_rex  input  4  REX W,R,X,B bits (bit3=W); byte = 0x40|in_rex
in_esc  input  1  emit 0x0F two-byte escape
in_opcode  input  8  primary opcode byte
in_has_modrm  input  1  emit ModRM byte
in_modrm  input  8  ModRM byte
in_has_sib  input  1  emit SIB byte (legal only with in_has_modrm)
in_sib  input  8  SIB byte
in_disp_len  input  3  displacement bytes; legal values 0, 1, 4
in_disp  input  32  displacement, low bytes used
in_imm_len  input  4  immediate bytes; legal values 0, 1, 2, 4, 8
in_imm  input  64  immediate, low bytes used
out_valid  output  1  out_byte valid
out_ready  input  1  consumer accepts byte
out_byte  output  8  stream byte
out_last  output  1  final byte of the current instruction
insn_len  output  4  length of the most recently accepted legal record
err  output  1  one-cycle pulse when a record is rejected
insn_count  output  CNT_W  count of completed instructions (last byte handshaked)

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; out_valid=0; out_byte=0; out_last=0; insn_len=0; err=0; insn_count=0; in_ready=1 after reset release. Reset mid-instruction discards the rest of the record; no further bytes are emitted.
- FSM states: IDLE, PFX, REX, ESC, OPC, MODRM, SIB, DISP, IMM.
  - Field order is fixed: 0x66, REX, 0x0F, opcode, ModRM, SIB, disp LSB-first, imm LSB-first.
  - Disabled fields are skipped with no bubble cycle.
- Accept occurs when in_valid && in_ready; all fields are latched on accept.
- Length = opsize + rex_en + esc + 1 + has_modrm + has_sib + disp_len + imm_len.
- Reject on accept when any of the following holds:
  - disp_len is not in {0,1,4};
  - imm_len is not in {0,1,2,4,8};
  - has_sib && !has_modrm;
  - length > MAX_LEN.
- On reject: err=1 for the next cycle only, state stays IDLE, nothing is emitted, insn_len is unchanged.
- On a legal accept:
  - insn_len is updated next cycle.
  - The first byte appears with out_valid=1 in the cycle after accept (1-cycle latency).
- Byte advance: advance on out_valid && out_ready. While out_ready=0, out_byte and out_last hold stable and out_valid stays high.
- The DISP and IMM states use a byte index counter:
  - It resets to 0 on state entry.
  - It increments on each handshake.
  - The state exits when index == len-1 is handshaked.
- out_last=1 exactly on the final byte.
- On that byte's handshake:
  - out_valid drops next cycle.
  - The FSM returns to IDLE.
  - insn_count increments, wrapping at 2^CNT_W.
- in_ready goes high the cycle after the last handshake, so each instruction costs N+1 cycles at full throughput.
- A one-byte instruction (only opcode) gives out_last=1 on the first byte.
- in_valid while busy is ignored; no record is lost because in_ready=0.

Test Plan:
- Encode "add rax, imm32": rex_en=1, rex=0x8, opcode=0x05, imm_len=4, imm=0x12345678, out_ready=1 -> bytes 48 05 78 56 34 12; out_last on 0x12; insn_len=6; insn_count=1.
- Encode "mov [rbx+0x10], eax": opcode=0x89, modrm=0x43, disp_len=1, disp=0x10 -> bytes 89 43 10.
- Repeat that record with out_ready toggling 1,0,0,1,… -> same 3 bytes, each held stable while stalled, no duplicates or drops.
- Encode a full record: opsize, rex 0x48, esc, opcode 0xAF, modrm 0x84, sib 0x24, disp_len=4 -> 66 48 0F AF 84 24 + 4 disp bytes; insn_len=10.
- Reject cases:
  - disp_len=3 -> err pulse 1 cycle, no out_valid, in_ready stays 1.
  - opsize+rex+esc+modrm+sib+disp4+imm8 (length 18) -> err, no bytes.
  - has_sib with has_modrm=0 -> err.
- Assert reset after 2 bytes of a 6-byte record -> out_valid=0 immediately; after release insn_count=0, in_ready=1, and the next record encodes from its first byte.
